// File: rtl/wdt_config_bank.sv
// wdt_config_bank
//   Write-protected configuration register bank shared by NCH windowed
//   watchdog channel cores. Each channel owns FWLEN, SWLEN, SERVICE and
//   RST_LMT. Lengths and limits can only change while a two-key unlock
//   sequence has opened the bank. Service pulses are accepted at any time.
//
// Ports
//   clk_i      clock, rising edge
//   rst_n_i    asynchronous active-low reset
//   wren_i     write strobe
//   rden_i     read strobe
//   abus_i     address: MSB=0 -> {ch, reg}; MSB=1 -> bit0 selects KEY(0)/STATUS(1)
//   dbus_i     write data
//   rdata_o    registered read data, held until the next read
//   rvalid_o   one-cycle pulse marking rdata_o valid
//   fwlen_o    first-window length, ch i at [i*DW +: DW]
//   swlen_o    second-window length, same packing
//   rst_lmt_o  reset limit, same packing
//   init_o     SERVICE[4] per channel
//   flstat_o   SERVICE[2:0] per channel
//   wdsrvc_o   one-cycle service pulse per channel
//   locked_o   high unless the bank is open
//   werr_o     sticky illegal-write flag, cleared by any STATUS write
//
// state  | meaning
// LOCKED | protected regs read-only, waiting for KEY1
// ARMED  | KEY1 seen, KEY2 must follow before the arm counter expires
// OPEN   | protected regs writable until the next KEY write
module wdt_config_bank #(
  parameter int          NCH    = 2,
  parameter int          DW     = 8,
  parameter logic [7:0]  KEY1   = 8'hA5,
  parameter logic [7:0]  KEY2   = 8'h5A,
  parameter int          ARM_TO = 16,
  parameter logic [DW-1:0] FW_RST = DW'(16),
  parameter logic [DW-1:0] SW_RST = DW'(16),
  parameter logic [DW-1:0] RL_RST = DW'(3),
  localparam int         CHW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int         AW     = CHW + 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wren_i,
  input  logic              rden_i,
  input  logic [AW-1:0]     abus_i,
  input  logic [DW-1:0]     dbus_i,
  output logic [DW-1:0]     rdata_o,
  output logic              rvalid_o,
  output logic [NCH*DW-1:0] fwlen_o,
  output logic [NCH*DW-1:0] swlen_o,
  output logic [NCH*DW-1:0] rst_lmt_o,
  output logic [NCH-1:0]    init_o,
  output logic [3*NCH-1:0]  flstat_o,
  output logic [NCH-1:0]    wdsrvc_o,
  output logic              locked_o,
  output logic              werr_o
);

  localparam int CW = (ARM_TO > 1) ? $clog2(ARM_TO) : 1;

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_ARMED  = 2'd1,
    ST_OPEN   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    werr_q, werr_d;
  logic [NCH-1:0][DW-1:0]  fw_q, fw_d;
  logic [NCH-1:0][DW-1:0]  sw_q, sw_d;
  logic [NCH-1:0][DW-1:0]  rl_q, rl_d;
  logic [NCH-1:0]          init_q, init_d;
  logic [NCH-1:0][2:0]     flstat_q, flstat_d;
  logic [NCH-1:0]          wdsrvc_q, wdsrvc_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic                    rvalid_q;

  logic            is_sys;
  logic [CHW-1:0]  ch;
  logic [1:0]      rsel;
  logic            ch_valid;
  logic            key_wr, stat_wr, ch_wr;
  logic            is_open;
  logic            werr_set;

  assign is_sys   = abus_i[AW-1];
  assign ch       = abus_i[CHW+1:2];
  assign rsel     = abus_i[1:0];
  assign ch_valid = (32'(ch) < NCH);
  assign key_wr   = wren_i &  is_sys & ~abus_i[0];
  assign stat_wr  = wren_i &  is_sys &  abus_i[0];
  assign ch_wr    = wren_i & ~is_sys;
  assign is_open  = (state_q == ST_OPEN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fw_d     = fw_q;
    sw_d     = sw_q;
    rl_d     = rl_q;
    init_d   = init_q;
    flstat_d = flstat_q;
    wdsrvc_d = '0;
    werr_set = 1'b0;

    unique case (state_q)
      ST_LOCKED: begin
        if (key_wr) begin
          if (dbus_i[7:0] == KEY1) begin
            state_d = ST_ARMED;
            cnt_d   = CW'(ARM_TO - 1);
          end else begin
            werr_set = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        // A KEY write takes priority over expiry on the terminal-count cycle.
        if (key_wr) begin
          if (dbus_i[7:0] == KEY2) begin
            state_d = ST_OPEN;
          end else begin
            state_d  = ST_LOCKED;
            werr_set = 1'b1;
          end
        end else if (cnt_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OPEN: begin
        if (key_wr) state_d = ST_LOCKED;
      end
      default: state_d = ST_LOCKED;
    endcase

    if (ch_wr) begin
      if (!ch_valid) begin
        werr_set = 1'b1;
      end else begin
        unique case (rsel)
          2'd0: begin
            if (!is_open || dbus_i == '0) werr_set = 1'b1;
            else                          fw_d[ch] = dbus_i;
          end
          2'd1: begin
            if (!is_open || dbus_i == '0) werr_set = 1'b1;
            else                          sw_d[ch] = dbus_i;
          end
          2'd2: begin
            // Service pulse is always honoured; status bits are protected.
            wdsrvc_d[ch] = dbus_i[3];
            if (is_open) begin
              init_d[ch]   = dbus_i[4];
              flstat_d[ch] = dbus_i[2:0];
            end else if (dbus_i[4] != init_q[ch] || dbus_i[2:0] != flstat_q[ch]) begin
              werr_set = 1'b1;
            end
          end
          default: begin
            if (!is_open) werr_set = 1'b1;
            else          rl_d[ch] = dbus_i;
          end
        endcase
      end
    end

    // Clearing through STATUS wins over a same-cycle error.
    werr_d = stat_wr ? 1'b0 : (werr_q | werr_set);
  end

  // Readback samples pre-write register values.
  always_comb begin
    rdata_d = rdata_q;
    if (rden_i) begin
      rdata_d = '0;
      if (is_sys) begin
        if (abus_i[0]) rdata_d = DW'({werr_q, state_q});
      end else if (ch_valid) begin
        unique case (rsel)
          2'd0:    rdata_d = fw_q[ch];
          2'd1:    rdata_d = sw_q[ch];
          2'd2:    rdata_d = DW'({init_q[ch], 1'b0, flstat_q[ch]});
          default: rdata_d = rl_q[ch];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_LOCKED;
      cnt_q    <= '0;
      werr_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        fw_q[i] <= FW_RST;
        sw_q[i] <= SW_RST;
        rl_q[i] <= RL_RST;
      end
      init_q   <= '0;
      flstat_q <= '0;
      wdsrvc_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      werr_q   <= werr_d;
      fw_q     <= fw_d;
      sw_q     <= sw_d;
      rl_q     <= rl_d;
      init_q   <= init_d;
      flstat_q <= flstat_d;
      wdsrvc_q <= wdsrvc_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rden_i;
    end
  end

  assign fwlen_o   = fw_q;
  assign swlen_o   = sw_q;
  assign rst_lmt_o = rl_q;
  assign init_o    = init_q;
  assign flstat_o  = flstat_q;
  assign wdsrvc_o  = wdsrvc_q;
  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign locked_o  = ~is_open;
  assign werr_o    = werr_q;

endmodule

// File: tb/tb_wdt_config_bank.sv
// tb_wdt_config_bank
//   Directed bench for wdt_config_bank with three channels, so that one
//   channel index (3) falls outside the implemented range.
module tb_wdt_config_bank;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int AW  = 5;

  localparam logic [AW-1:0] A_KEY  = 5'b10000;
  localparam logic [AW-1:0] A_STAT = 5'b10001;

  logic              clk;
  logic              rst_n;
  logic              wren;
  logic              rden;
  logic [AW-1:0]     abus;
  logic [DW-1:0]     dbus;
  logic [DW-1:0]     rdata;
  logic              rvalid;
  logic [NCH*DW-1:0] fwlen;
  logic [NCH*DW-1:0] swlen;
  logic [NCH*DW-1:0] rst_lmt;
  logic [NCH-1:0]    init;
  logic [3*NCH-1:0]  flstat;
  logic [NCH-1:0]    wdsrvc;
  logic              locked;
  logic              werr;

  int vectors;
  int miscompares;

  wdt_config_bank #(.NCH(NCH), .DW(DW)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .wren_i    (wren),
    .rden_i    (rden),
    .abus_i    (abus),
    .dbus_i    (dbus),
    .rdata_o   (rdata),
    .rvalid_o  (rvalid),
    .fwlen_o   (fwlen),
    .swlen_o   (swlen),
    .rst_lmt_o (rst_lmt),
    .init_o    (init),
    .flstat_o  (flstat),
    .wdsrvc_o  (wdsrvc),
    .locked_o  (locked),
    .werr_o    (werr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] ra(input int c, input int r);
    return {1'b0, 2'(c), 2'(r)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge; each takes one cycle.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wren = 1'b1; abus = a; dbus = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rden = 1'b1; abus = a;
    @(negedge clk);
    rden = 1'b0;
  endtask

  task automatic rdwr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rden = 1'b1; wren = 1'b1; abus = a; dbus = d;
    @(negedge clk);
    rden = 1'b0; wren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; wren = 1'b0; rden = 1'b0; abus = '0; dbus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fwlen",  32'(fwlen),   32'h101010);
    chk("rst_swlen",  32'(swlen),   32'h101010);
    chk("rst_rstlmt", 32'(rst_lmt), 32'h030303);
    chk("rst_locked", 32'(locked),  32'd1);
    chk("rst_werr",   32'(werr),    32'd0);
    chk("rst_wdsrvc", 32'(wdsrvc),  32'd0);
    chk("rst_rvalid", 32'(rvalid),  32'd0);
    chk("rst_rdata",  32'(rdata),   32'd0);
    rst_n = 1'b1;
    idle(1);

    // Locked write is rejected and flags an error; STATUS write clears it.
    wr(ra(0, 0), 8'h20);
    chk("lk_fwlen", 32'(fwlen), 32'h101010);
    chk("lk_werr",  32'(werr),  32'd1);
    rd(A_STAT);
    chk("lk_stat_rd",  32'(rdata),  32'h04);
    chk("lk_stat_rv",  32'(rvalid), 32'd1);
    wr(A_STAT, 8'h00);
    chk("lk_werr_clr", 32'(werr),   32'd0);
    chk("rv_drop",     32'(rvalid), 32'd0);
    chk("rdata_hold",  32'(rdata),  32'h04);

    // Unlock sequence with three idle cycles in between.
    wr(A_KEY, 8'hA5);
    chk("arm_locked", 32'(locked), 32'd1);
    rd(A_STAT);
    chk("arm_state", 32'(rdata), 32'h01);
    idle(2);
    wr(A_KEY, 8'h5A);
    chk("open_locked", 32'(locked), 32'd0);
    rd(A_STAT);
    chk("open_state", 32'(rdata), 32'h02);
    wr(ra(1, 1), 8'h40);
    chk("open_swlen", 32'(swlen), 32'h104010);
    wr(ra(2, 3), 8'h07);
    chk("open_rstlmt", 32'(rst_lmt), 32'h070303);
    chk("open_werr",   32'(werr),    32'd0);

    // Zero length is rejected even while open.
    wr(ra(0, 0), 8'h00);
    chk("zero_fwlen", 32'(fwlen), 32'h101010);
    chk("zero_werr",  32'(werr),  32'd1);
    wr(A_STAT, 8'h00);

    // Out-of-range channel.
    wr(ra(3, 0), 8'h55);
    chk("ch3_werr",  32'(werr),  32'd1);
    chk("ch3_fwlen", 32'(fwlen), 32'h101010);
    wr(A_STAT, 8'h00);
    rd(ra(0, 0));
    chk("rd_fw0", 32'(rdata), 32'h10);
    rd(ra(3, 0));
    chk("rd_ch3",    32'(rdata),  32'h00);
    chk("rd_ch3_rv", 32'(rvalid), 32'd1);
    rd(A_KEY);
    chk("rd_key", 32'(rdata), 32'h00);

    // Service store while open: bit 3 pulses, bits 4 and 2:0 stored.
    wr(ra(0, 2), 8'h1D);
    chk("svc_pulse",  32'(wdsrvc), 32'b001);
    chk("svc_init",   32'(init),   32'b001);
    chk("svc_flstat", 32'(flstat), 32'h005);
    idle(1);
    chk("svc_pulse_end", 32'(wdsrvc), 32'b000);
    rd(ra(0, 2));
    chk("svc_rd", 32'(rdata), 32'h15);

    // Same-cycle read and write returns the old value.
    rdwr(ra(1, 0), 8'h33);
    chk("rdwr_rdata", 32'(rdata), 32'h10);
    chk("rdwr_fwlen", 32'(fwlen), 32'h103310);

    // Any KEY write relocks without error.
    wr(A_KEY, 8'h00);
    chk("relock",      32'(locked), 32'd1);
    chk("relock_werr", 32'(werr),   32'd0);

    // Arm timeout: last usable cycle for KEY2 is the 16th after KEY1.
    wr(A_KEY, 8'hA5);
    idle(15);
    wr(A_KEY, 8'h5A);
    chk("to_edge_open", 32'(locked), 32'd0);
    wr(A_KEY, 8'h00);
    wr(A_KEY, 8'hA5);
    idle(16);
    chk("to_expire_werr", 32'(werr), 32'd0);
    rd(A_STAT);
    chk("to_expire_state", 32'(rdata), 32'h00);
    wr(A_KEY, 8'h5A);
    chk("to_late_locked", 32'(locked), 32'd1);
    chk("to_late_werr",   32'(werr),   32'd1);
    wr(A_STAT, 8'h00);

    // Service while locked.
    wr(ra(1, 2), 8'h08);
    chk("lsvc_pulse", 32'(wdsrvc), 32'b010);
    chk("lsvc_werr",  32'(werr),   32'd0);
    idle(1);
    chk("lsvc_pulse_end", 32'(wdsrvc), 32'b000);
    chk("lsvc_init",      32'(init),   32'b001);
    chk("lsvc_flstat",    32'(flstat), 32'h005);
    rd(ra(1, 2));
    chk("lsvc_rd", 32'(rdata), 32'h00);
    wr(ra(0, 2), 8'h08);
    chk("lsvc_mis_pulse", 32'(wdsrvc), 32'b001);
    chk("lsvc_mis_werr",  32'(werr),   32'd1);
    chk("lsvc_mis_init",  32'(init),   32'b001);
    wr(ra(2, 3), 8'h09);
    chk("lk_rstlmt", 32'(rst_lmt), 32'h070303);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
